// File: rtl/bht_pkg.sv
// Shared types and helpers for the set-associative branch history table.
// Entry fields are sized for the widest legal configuration.
// Narrower builds keep their unused upper bits at zero.
package bht_pkg;

    localparam int BHT_MAX_TAG_W = 32;
    localparam int BHT_MAX_CNT_W = 4;

    typedef struct packed {
        logic                     valid;
        logic [BHT_MAX_TAG_W-1:0] tag;
        logic [BHT_MAX_CNT_W-1:0] count;
    } bht_entry_t;

    // Weakly-taken counter value: MSB set, all other bits clear
    function automatic int bht_cnt_wt(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    // Weakly-not-taken counter value: MSB clear, all other bits set
    function automatic int bht_cnt_wn(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Tag is everything above the index field and the ignored byte-offset bits
    function automatic logic [31:0] bht_tag(input logic [31:0] pc, input int index_w);
        return pc >> (index_w + 2);
    endfunction

    // Index sits directly above pc[1:0]
    function automatic logic [31:0] bht_index(input logic [31:0] pc, input int index_w);
        return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bht_repl.sv
// Per-set replacement state and victim selection.
// Define BHT_LRU_EN to select tree pseudo-LRU (WAYS-1 bits per set).
// Otherwise a round-robin pointer is used; the top only touches it on evicting allocations.
module bht_repl
    import bht_pkg::*;
#(
    parameter int INDEX_W = 7,
    parameter int WAYS    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INDEX_W-1:0]       set,
    input  logic                     touch_valid,
    input  logic [$clog2(WAYS)-1:0]  touch_way,
    output logic [$clog2(WAYS)-1:0]  victim_way
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int WAY_W = $clog2(WAYS);

`ifdef BHT_LRU_EN
    logic [WAYS-2:0] tree_q [SETS];
    logic [WAYS-2:0] tree_cur;
    logic [WAYS-2:0] tree_nxt;

    assign tree_cur = tree_q[set];

    if (WAYS == 2) begin : g_tree2
        // Single bit names the victim; touching a way points it at the other one
        always_comb begin
            victim_way = tree_cur[0];
            tree_nxt   = ~touch_way;
        end
    end else begin : g_tree4
        // Root bit picks the pair, leaf bits pick within the pair; touches point away
        always_comb begin
            victim_way  = {tree_cur[0], (tree_cur[0] ? tree_cur[2] : tree_cur[1])};
            tree_nxt    = tree_cur;
            tree_nxt[0] = ~touch_way[1];
            if (touch_way[1]) begin
                tree_nxt[2] = ~touch_way[0];
            end else begin
                tree_nxt[1] = ~touch_way[0];
            end
        end
    end

    // Tree bits update on every touch of the set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else if (touch_valid) begin
            tree_q[set] <= tree_nxt;
        end
    end
`else
    logic [WAY_W-1:0] ptr_q [SETS];

    assign victim_way = ptr_q[set];

    // Pointer moves past the way just evicted, wrapping at WAYS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (touch_valid) begin
            ptr_q[set] <= WAY_W'(touch_way + 1'b1);
        end
    end
`endif

endmodule

// File: rtl/bht_set_assoc.sv
// N-way set-associative branch history table with saturating counters.
// Lookup is combinational; updates allocate on miss and write at the clock edge.
// Replacement policy is selected by BHT_LRU_EN (pseudo-LRU) or round-robin when undefined.
module bht_set_assoc
    import bht_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INDEX_W = 7,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             lookup_hit,
    output logic [CNT_W-1:0] lookup_count,
    output logic             lookup_taken,
    input  logic             update_valid,
    input  logic [PC_W-1:0]  update_pc,
    input  logic             update_taken,
    input  logic             flush
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = PC_W - INDEX_W - 2;
    localparam int WAY_W = $clog2(WAYS);

    localparam logic [BHT_MAX_CNT_W-1:0] CNT_MAX = BHT_MAX_CNT_W'((1 << CNT_W) - 1);
    localparam logic [BHT_MAX_CNT_W-1:0] CNT_WT  = BHT_MAX_CNT_W'(bht_cnt_wt(CNT_W));
    localparam logic [BHT_MAX_CNT_W-1:0] CNT_WN  = BHT_MAX_CNT_W'(bht_cnt_wn(CNT_W));

    bht_entry_t table_q [SETS][WAYS];

    logic [INDEX_W-1:0]       lk_idx;
    logic [TAG_W-1:0]         lk_tag;
    logic [INDEX_W-1:0]       up_idx;
    logic [TAG_W-1:0]         up_tag;
    logic                     up_hit;
    logic [WAY_W-1:0]         hit_way;
    logic                     free_found;
    logic [WAY_W-1:0]         free_way;
    logic [WAY_W-1:0]         tgt_way;
    logic [WAY_W-1:0]         repl_victim;
    logic [BHT_MAX_CNT_W-1:0] old_cnt;
    logic [BHT_MAX_CNT_W-1:0] new_cnt;
    logic                     repl_touch;

    assign lk_idx = INDEX_W'(bht_index(32'(lookup_pc), INDEX_W));
    assign lk_tag = TAG_W'(bht_tag(32'(lookup_pc), INDEX_W));
    assign up_idx = INDEX_W'(bht_index(32'(update_pc), INDEX_W));
    assign up_tag = TAG_W'(bht_tag(32'(update_pc), INDEX_W));

    // Lookup reads the pre-edge table only; a miss reports zero count and not-taken
    always_comb begin
        lookup_hit   = 1'b0;
        lookup_count = '0;
        lookup_taken = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (table_q[lk_idx][w].valid && (table_q[lk_idx][w].tag == 32'(lk_tag))) begin
                lookup_hit   = 1'b1;
                lookup_count = CNT_W'(table_q[lk_idx][w].count);
                lookup_taken = table_q[lk_idx][w].count[CNT_W-1];
            end
        end
    end

    // Pick the target way (hit way, else lowest invalid, else policy victim) and its new counter
    always_comb begin
        up_hit     = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        old_cnt    = '0;
        new_cnt    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (table_q[up_idx][w].valid && (table_q[up_idx][w].tag == 32'(up_tag))) begin
                up_hit  = 1'b1;
                hit_way = WAY_W'(w);
                old_cnt = table_q[up_idx][w].count;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!table_q[up_idx][w].valid) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
        tgt_way = up_hit ? hit_way : (free_found ? free_way : repl_victim);
        if (up_hit) begin
            if (update_taken) begin
                new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + 1'b1;
            end else begin
                new_cnt = (old_cnt == '0) ? old_cnt : old_cnt - 1'b1;
            end
        end else begin
            new_cnt = update_taken ? CNT_WT : CNT_WN;
        end
    end

`ifdef BHT_LRU_EN
    assign repl_touch = update_valid && !flush;
`else
    assign repl_touch = update_valid && !flush && !up_hit && !free_found;
`endif

    bht_repl #(
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS)
    ) u_repl (
        .clk         (clk),
        .reset       (reset),
        .set         (up_idx),
        .touch_valid (repl_touch),
        .touch_way   (tgt_way),
        .victim_way  (repl_victim)
    );

    // Table storage: async clear on reset, flush drops valid bits and wins over an update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    table_q[s][w] <= '0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    table_q[s][w].valid <= 1'b0;
                end
            end
        end else if (update_valid) begin
            table_q[up_idx][tgt_way] <= '{valid: 1'b1, tag: 32'(up_tag), count: new_cnt};
        end
    end

endmodule

// File: doc/bht_set_assoc.md
# bht_set_assoc

Parametrised, N-way set-associative branch history table with per-entry saturating counters, tag allocation on miss, and a selectable replacement policy. It generalises the fixed 2-bit, single-port branch history table with separate lookup and update ports, configurable geometry, flush, and defined replacement. It sits in fetch:
- The lookup port predicts the current PC combinationally.
- The update port is driven from execute when a branch resolves.

## Interface
- PC_W, 16: PC width.
- INDEX_W, 7: set index bits; sets = 2**INDEX_W.
- WAYS, 2: associativity; legal values 2 or 4.
- CNT_W, 2: counter width; legal range 2..4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  PC_W  PC to predict.
- lookup_hit  out  1  tag match in a valid way.
- lookup_count  out  CNT_W  matching counter; 0 on miss.
- lookup_taken  out  1  counter MSB when hit; 0 on miss.
- update_valid  in  1  resolved branch this cycle.
- update_pc  in  PC_W  PC of the resolved branch.
- update_taken  in  1  resolved direction.
- flush  in  1  invalidate all entries.

## Operation
- Address fields:
  - tag = pc[PC_W-1:INDEX_W+2].
  - index = pc[INDEX_W+1:2].
  - pc[1:0] is ignored.
- Each entry holds valid, tag and counter. Each set holds the replacement state.
- Lookup is purely combinational and never modifies any state.
- Update hit (update_valid, tag matches a valid way in the set):
  - Counter saturating +1 if update_taken, −1 otherwise.
  - Saturation limits are 2**CNT_W−1 and 0.
  - The way is marked most recently used.
- Update miss allocates a victim way:
  - Victim is the lowest-numbered invalid way, else the way chosen by the policy.
  - Written with valid=1 and the new tag.
  - Counter = WT (2**(CNT_W−1)) if update_taken, else WN (2**(CNT_W−1)−1).
  - The way is marked most recently used.
- flush clears every valid bit at the clock edge. flush has priority over a same-cycle update, which is dropped.
- Reset (asserted low) immediately clears all valid bits, counters and replacement state. All outputs go to 0 while reset is low.
- A lookup and an update in the same cycle to the same set: the lookup reflects pre-edge contents. There is no bypass.
- Multiple valid ways matching the same tag cannot occur by construction. No handling is required.

## Timing
- Lookup latency: 0 cycles (combinational from lookup_pc).
- Update latency: state is written at the rising edge and visible to lookup from that edge onward.
- Reset values:
  - lookup_hit = 0, lookup_count = 0, lookup_taken = 0.
  - All valid bits = 0, all replacement state = 0.
- Deassertion of reset takes effect asynchronously. The first update is accepted at the first rising edge with reset high.
- Back-to-back updates to the same entry on consecutive cycles each apply. There is no stall and no hazard.

## Configuration
- BHT_LRU_EN defined:
  - Per-set tree pseudo-LRU: WAYS−1 bits per set.
  - Every update (hit or allocate) points the tree away from the touched way.
  - The victim is the way the tree points to.
- BHT_LRU_EN undefined:
  - Per-set round-robin pointer of log2(WAYS) bits.
  - The victim is the pointer way. The pointer increments, wrapping, only on evicting allocations.
  - Hits and allocations into invalid ways leave the pointer unchanged.

## Structure
- Package bht_pkg holds:
  - Counter constants CNT_WT and CNT_WN as functions of CNT_W.
  - Functions bht_tag() and bht_index().
  - An entry struct typedef {valid, tag, count}.
- Sub-module bht_repl holds the per-set replacement state and victim selection. Its internals are switched by BHT_LRU_EN.
  - Inputs: set, touch_valid, touch_way.
  - Output: victim_way.
- Counter arrays are flop-based, so reset can clear them asynchronously.

## Test plan
Default parameters (WAYS=2, CNT_W=2); all PCs below map to index 0x05.
- Reset released, lookup_pc=16'h0A14 -> lookup_hit=0, lookup_count=0, lookup_taken=0.
- Update 16'h0A14 taken (miss) -> next cycle lookup 16'h0A14: hit=1, count=2'b10, taken=1.
- Counter saturation:
  - Two more taken updates to 16'h0A14 -> count=2'b11, holds at 2'b11.
  - Then four not-taken updates -> 2'b10, 2'b01, 2'b00, 2'b00; taken=0.
- Replacement sequence:
  - Update 16'h0A14 (allocates way0), then 16'h0C14 (allocates way1), then 16'h0A14 (hit), then 16'h0E14 (evicting allocation).
  - With BHT_LRU_EN: lookup 16'h0C14 misses; 16'h0A14 and 16'h0E14 hit.
  - Without BHT_LRU_EN: lookup 16'h0A14 misses; 16'h0C14 and 16'h0E14 hit.
- flush=1 with update_valid=1 for 16'h1014 in the same cycle -> next cycle every lookup misses, including 16'h1014.
- Populate 16'h0A14, then drop reset low mid-cycle between edges -> lookup_hit falls to 0 immediately. After release, 16'h0A14 still misses.
